// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: PC defaults, fetch FSM states and the IF/ID record.
package mips_pkg;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam int unsigned DefaultPcStep  = 4;
  localparam logic [31:0] Nop            = 32'h0000_0000;

  typedef enum logic [0:0] {
    StFetch = 1'b0,
    StHold  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } ifid_t;

  localparam ifid_t IfidEmpty = '{valid: 1'b0, instr: Nop, pc_plus4: 32'h0000_0000};

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and instruction memory.
interface mips_fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/mips_ifid_reg.sv
// IF/ID pipeline register: flush clears valid only, load captures a new record, otherwise hold.
module mips_ifid_reg
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load_i,
  input  logic  flush_i,
  input  ifid_t d_i,
  output ifid_t q_o
);

  ifid_t ifid_q, ifid_d;

  always_comb begin
    ifid_d = ifid_q;
    if (flush_i) begin
      ifid_d.valid = 1'b0;
    end else if (load_i) begin
      ifid_d = d_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_q <= IfidEmpty;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign q_o = ifid_q;

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues imem requests and fills the IF/ID register,
// parking one word in a hold buffer when decode stalls on a completed fetch.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc,
  parameter int unsigned PC_STEP  = DefaultPcStep
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                redirect_valid_i,
  input  logic [31:0]         redirect_pc_i,
  mips_fetch_stage_if.master  imem,
  output logic [31:0]         pc_out_o,
  output logic                ifid_valid_o,
  output logic [31:0]         ifid_instr_o,
  output logic [31:0]         ifid_pc_plus4_o
);

  localparam logic [31:0] Step = PC_STEP;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  ifid_t        hold_q, hold_d;

  logic         ifid_load;
  logic         ifid_flush;
  ifid_t        ifid_next;
  ifid_t        ifid_cur;
  logic [31:0]  pc_next_seq;
  logic [31:0]  redirect_tgt;

  assign pc_next_seq  = pc_q + Step;
  assign redirect_tgt = redirect_pc_i & ~32'h0000_0003;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_next  = '{valid: 1'b1, instr: imem.imem_rdata, pc_plus4: pc_next_seq};

    unique case (state_q)
      StFetch: begin
        if (redirect_valid_i) begin
          pc_d       = redirect_tgt;
          ifid_flush = 1'b1;
        end else if (imem.imem_ready && !stall_i) begin
          ifid_load = 1'b1;
          pc_d      = pc_next_seq;
        end else if (imem.imem_ready) begin
          // Decode is stalled but the word arrived: park it rather than refetch.
          hold_d  = '{valid: 1'b1, instr: imem.imem_rdata, pc_plus4: pc_next_seq};
          state_d = StHold;
        end else if (!stall_i) begin
          ifid_flush = 1'b1;
        end
      end
      StHold: begin
        if (redirect_valid_i) begin
          hold_d     = IfidEmpty;
          pc_d       = redirect_tgt;
          ifid_flush = 1'b1;
          state_d    = StFetch;
        end else if (!stall_i) begin
          ifid_next = hold_q;
          ifid_load = 1'b1;
          hold_d    = IfidEmpty;
          pc_d      = pc_next_seq;
          state_d   = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      hold_q  <= IfidEmpty;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  mips_ifid_reg u_ifid_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .d_i     (ifid_next),
    .q_o     (ifid_cur)
  );

  assign imem.imem_req  = (state_q == StFetch) && !reset;
  assign imem.imem_addr = pc_q;

  assign pc_out_o        = pc_q;
  assign ifid_valid_o    = ifid_cur.valid;
  assign ifid_instr_o    = ifid_cur.instr;
  assign ifid_pc_plus4_o = ifid_cur.pc_plus4;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: sequential fetch, wait states, stall/hold, redirects,
// PC wrap and asynchronous reset, with a second instance reset to the top of the address space.
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ready;

  logic [31:0] pc_out, ifid_instr, ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] pc_out2, ifid_instr2, ifid_pc_plus42;
  logic        ifid_valid2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return 32'h2400_0000 ^ {a[15:0], a[15:0]} ^ 32'h0000_5A5A;
  endfunction

  mips_fetch_stage_if imem ();
  mips_fetch_stage_if imem2 ();

  assign imem.imem_rdata  = instr_at(imem.imem_addr);
  assign imem.imem_ready  = ready;
  assign imem2.imem_rdata = instr_at(imem2.imem_addr);
  assign imem2.imem_ready = ready;

  mips_fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem             (imem.master),
    .pc_out_o         (pc_out),
    .ifid_valid_o     (ifid_valid),
    .ifid_instr_o     (ifid_instr),
    .ifid_pc_plus4_o  (ifid_pc_plus4)
  );

  mips_fetch_stage #(
    .RESET_PC (32'hFFFF_FFFC),
    .PC_STEP  (4)
  ) dut_wrap (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .imem             (imem2.master),
    .pc_out_o         (pc_out2),
    .ifid_valid_o     (ifid_valid2),
    .ifid_instr_o     (ifid_instr2),
    .ifid_pc_plus4_o  (ifid_pc_plus42)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pp4);
    check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
    if (v) check({tag, ".instr"}, ifid_instr, ins);
    check({tag, ".pc_plus4"}, ifid_pc_plus4, pp4);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ready = 1'b1;

    #2;
    check("rst.req", {31'd0, imem.imem_req}, 32'd0);
    check("rst.pc", pc_out, 32'h0);
    check("rst.valid", {31'd0, ifid_valid}, 32'd0);
    check("rst.instr", ifid_instr, 32'h0);
    check("rst.pp4", ifid_pc_plus4, 32'h0);
    check("rst.pc_wrap", pc_out2, 32'hFFFF_FFFC);

    @(negedge clk); reset = 1'b0;                                 // t=10
    #1;
    check("rel.req", {31'd0, imem.imem_req}, 32'd1);
    check("rel.pc", pc_out, 32'h0);
    check("rel.addr", imem.imem_addr, 32'h0);

    @(negedge clk);                                               // t=20
    check("seq1.pc", pc_out, 32'h4);
    check_ifid("seq1", 1'b1, instr_at(32'h0), 32'h4);
    check("wrap.pc", pc_out2, 32'h0);
    check("wrap.pp4", ifid_pc_plus42, 32'h0);
    check("wrap.instr", ifid_instr2, instr_at(32'hFFFF_FFFC));

    @(negedge clk);                                               // t=30
    check("seq2.pc", pc_out, 32'h8);
    check_ifid("seq2", 1'b1, instr_at(32'h4), 32'h8);
    ready = 1'b0;

    @(negedge clk);                                               // t=40
    check("wait1.pc", pc_out, 32'h8);
    check("wait1.valid", {31'd0, ifid_valid}, 32'd0);
    @(negedge clk);                                               // t=50
    check("wait2.pc", pc_out, 32'h8);
    check("wait2.valid", {31'd0, ifid_valid}, 32'd0);
    ready = 1'b1;

    @(negedge clk);                                               // t=60
    check("wait3.pc", pc_out, 32'hC);
    check_ifid("wait3", 1'b1, instr_at(32'h8), 32'hC);

    @(negedge clk);                                               // t=70
    check("pre_stall.pc", pc_out, 32'h10);
    check_ifid("pre_stall", 1'b1, instr_at(32'hC), 32'h10);
    stall = 1'b1;

    for (int i = 0; i < 3; i++) begin                             // t=80,90,100
      @(negedge clk);
      check("hold.req", {31'd0, imem.imem_req}, 32'd0);
      check("hold.pc", pc_out, 32'h10);
      check_ifid("hold", 1'b1, instr_at(32'hC), 32'h10);
    end
    stall = 1'b0;

    @(negedge clk);                                               // t=110
    check("unhold.pc", pc_out, 32'h14);
    check("unhold.req", {31'd0, imem.imem_req}, 32'd1);
    check_ifid("unhold", 1'b1, instr_at(32'h10), 32'h14);

    @(negedge clk);                                               // t=120
    check("seq3.pc", pc_out, 32'h18);
    check_ifid("seq3", 1'b1, instr_at(32'h14), 32'h18);
    @(negedge clk);                                               // t=130
    check("seq4.pc", pc_out, 32'h1C);
    @(negedge clk);                                               // t=140
    check("seq5.pc", pc_out, 32'h20);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;

    @(negedge clk);                                               // t=150
    check("redir.pc", pc_out, 32'h40);
    check("redir.valid", {31'd0, ifid_valid}, 32'd0);
    redirect_valid = 1'b0;

    @(negedge clk);                                               // t=160
    check("redir2.pc", pc_out, 32'h44);
    check_ifid("redir2", 1'b1, instr_at(32'h40), 32'h44);
    stall = 1'b1;

    @(negedge clk);                                               // t=170
    check("hold2.req", {31'd0, imem.imem_req}, 32'd0);
    check_ifid("hold2", 1'b1, instr_at(32'h40), 32'h44);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;

    @(negedge clk);                                               // t=180
    check("hredir.pc", pc_out, 32'h100);
    check("hredir.valid", {31'd0, ifid_valid}, 32'd0);
    check("hredir.req", {31'd0, imem.imem_req}, 32'd1);
    redirect_valid = 1'b0; stall = 1'b0;

    @(negedge clk);                                               // t=190
    check("hredir2.pc", pc_out, 32'h104);
    check_ifid("hredir2", 1'b1, instr_at(32'h100), 32'h104);
    stall = 1'b1;

    @(negedge clk);                                               // t=200
    check("hold3.req", {31'd0, imem.imem_req}, 32'd0);
    #2 reset = 1'b1;                                              // t=202, off-edge
    #1;
    check("arst.pc", pc_out, 32'h0);
    check("arst.valid", {31'd0, ifid_valid}, 32'd0);
    check("arst.instr", ifid_instr, 32'h0);
    check("arst.pp4", ifid_pc_plus4, 32'h0);
    check("arst.req", {31'd0, imem.imem_req}, 32'd0);

    @(negedge clk); reset = 1'b0; stall = 1'b0;                   // t=210
    @(negedge clk);                                               // t=220
    check("post.pc", pc_out, 32'h4);
    check_ifid("post", 1'b1, instr_at(32'h0), 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch (IF) stage of the MIPS pipeline. It sits directly upstream of the decode/register-file stage.
- Owns the program counter and drives the instruction-memory request.
- Captures fetched words into the IF/ID pipeline register.
- Handles hazard-unit stalls and branch/jump redirects, which flush the stage.
- Its pc_out is the PC value the top-level testbench monitors.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  single clock; all registers update on posedge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  from hazard unit; IF/ID consumer is not accepting this cycle.
- redirect_valid  in  1  branch/jump taken; redirect_pc is the new target.
- redirect_pc  in  32  target address; bits [1:0] are ignored (treated as 0).
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  fetch address; always equals pc_out.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  same-cycle response to the current imem_req/imem_addr.
- pc_out  out  32  current fetch PC.
- ifid_valid  out  1  IF/ID register holds a valid instruction.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc_plus4  out  32  IF/ID PC of that instruction + PC_STEP.

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-wait):
  - pc=RESET_PC, state=FETCH, ifid_valid=0, ifid_instr=0, ifid_pc_plus4=0, hold buffer invalid.
  - imem_req is 0 while reset is asserted and 1 in the first cycle after release.
- Memory protocol:
  - No outstanding transactions.
  - imem_ready is meaningful only in a cycle where imem_req=1; it is ignored otherwise.
  - The stage may change imem_addr or drop imem_req in any cycle; there is no abort handshake.
- FSM states: FETCH, HOLD.
- FETCH: imem_req=1, imem_addr=pc.
  - redirect_valid: pc<=redirect_pc&~3; ifid_valid<=0; stay FETCH. Any imem_ready this cycle is discarded.
  - else imem_ready & !stall: ifid_valid<=1; ifid_instr<=imem_rdata; ifid_pc_plus4<=pc+PC_STEP; pc<=pc+PC_STEP. Fetch latency is 1 cycle.
  - else imem_ready & stall: hold buffer <= {imem_rdata, pc+PC_STEP}; IF/ID unchanged; pc unchanged; go HOLD.
  - else !imem_ready: pc unchanged. If !stall, ifid_valid<=0 (bubble). If stall, IF/ID holds.
- HOLD: imem_req=0.
  - redirect_valid: flush the hold buffer; pc<=redirect_pc&~3; ifid_valid<=0; go FETCH.
  - else stall: all registers hold.
  - else: IF/ID <= hold buffer with valid=1; pc<=pc+PC_STEP; go FETCH.
- Priority, highest first: reset > redirect_valid > stall > imem_ready.
- Redirect in the same cycle as stall: the redirect wins and flushes. The decode instruction causing the stall is the branch itself, and the flush is required.
- Arithmetic: pc+PC_STEP is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- While stall is high, ifid_* outputs must not change unless redirect_valid is high.
- Holding across multiple imem_ready cycles during a stall is forbidden. Only one word is buffered, which is why the FSM leaves FETCH.

Decomposition:
- Shared package mips_pkg holds:
  - RESET_PC default and PC_STEP;
  - NOP encoding 32'h0000_0000;
  - the fetch-state enum {FETCH, HOLD};
  - an ifid_t struct {valid, instr[31:0], pc_plus4[31:0]}, reused by the decode stage.
- One natural sub-module: mips_ifid_reg, the IF/ID pipeline register with load/flush/hold controls and asynchronous reset. The FSM and PC logic stay in the top module.

Test Plan:
- Reset and sequential fetch: reset high 10 ns, then low; imem_ready=1 always; rdata=addr-derived pattern.
  - pc_out goes 0,4,8,C on successive cycles.
  - ifid_instr lags one cycle; ifid_pc_plus4 = 4,8,C.
- Wait states: imem_ready low for 2 cycles at pc=8.
  - pc_out holds 8 for 3 cycles; ifid_valid=0 for 2 cycles; then instr@8 with ifid_pc_plus4=C.
- Stall with buffering: stall high 3 cycles while ready=1 at pc=10.
  - Enters HOLD; imem_req=0; ifid unchanged throughout.
  - On stall release: ifid=instr@10, pc_plus4=14; next pc_out=14.
- Redirect: redirect_valid with redirect_pc=32'h0000_0043 at pc=20.
  - Next cycle: pc_out=40, ifid_valid=0; following cycle: ifid=instr@40, pc_plus4=44.
- Redirect during HOLD plus simultaneous stall: buffered word is discarded; pc_out=redirect target; ifid_valid=0.
- Wrap and asynchronous reset:
  - RESET_PC=FFFF_FFFC: ifid_pc_plus4=0; next pc_out=0.
  - Reset asserted mid-HOLD, off-edge: outputs clear immediately without waiting for clk.
